// File: rtl/pwm_audio_out_pkg.sv
// Shared definitions for the PWM audio output path; the MMIO decode reuses
// the defaults and state encoding.
package pwm_audio_out_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

  localparam int PWM_WIDTH_DEF    = 8;
  localparam int PWM_PRESCALE_DEF = 50;

  // Prescaler needs at least one bit even when PRESCALE == 1.
  function automatic int presc_bits(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks while en is high,
// held at zero while en is low.
module pwm_tick_gen
  import pwm_audio_out_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int PW = presc_bits(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: one-deep shadow buffer feeding a duty register that only
// changes on period boundaries, so periods are never truncated.
module pwm_audio_out
  import pwm_audio_out_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH_DEF,
  parameter int PRESCALE = PWM_PRESCALE_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             rest,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             clr_underrun,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun
);

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_duty_q, active_duty_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             pwm_out_q, pwm_out_d;
  logic             period_start_q, period_start_d;
  logic             underrun_q, underrun_d;

  logic run, tick, boundary, xfer;

  assign run          = (state_q == RUN);
  assign sample_ready = !shadow_full_q;
  assign xfer         = sample_valid && !shadow_full_q;
  assign boundary     = tick && (count_q == {WIDTH{1'b1}});

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clock (clock),
    .reset (reset),
    .en    (run),
    .tick  (tick)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = '0;
    active_duty_d  = active_duty_q;
    shadow_d       = shadow_q;
    shadow_full_d  = shadow_full_q;
    underrun_d     = underrun_q;

    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (run) count_d = tick ? count_q + 1'b1 : count_q;

    if (clr_underrun) underrun_d = 1'b0;

    if (boundary) begin
      if (shadow_full_q) begin
        active_duty_d = shadow_q;
        shadow_full_d = 1'b0;
      end else if (xfer) begin
        // Sample arriving exactly at the wrap skips the shadow entirely.
        active_duty_d = sample_data;
      end else begin
        underrun_d = 1'b1;
      end
    end else begin
      // While idle the shadow drains straight into the duty register so the
      // first period after enable already plays it.
      if (!run && shadow_full_q) begin
        active_duty_d = shadow_q;
        shadow_full_d = 1'b0;
      end
      if (xfer) begin
        shadow_d      = sample_data;
        shadow_full_d = 1'b1;
      end
    end

    pwm_out_d      = run && enable && !rest && (count_q < active_duty_q);
    period_start_d = boundary || ((state_q == IDLE) && enable);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      active_duty_q  <= '0;
      shadow_q       <= '0;
      shadow_full_q  <= 1'b0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      active_duty_q  <= active_duty_d;
      shadow_q       <= shadow_d;
      shadow_full_q  <= shadow_full_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out with WIDTH=4, PRESCALE=2 (32-clock periods).
module tb_pwm_audio_out;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       rest;
  logic [3:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic       clr_underrun;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;

  int vec_cnt = 0;
  int err_cnt = 0;

  pwm_audio_out #(.WIDTH(4), .PRESCALE(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .rest         (rest),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .clr_underrun (clr_underrun),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] duty;
    logic       mute;
    int         exp_hi;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called on a period_start cycle; observes the 32 pwm samples that belong
  // to the period which just started and ends on the next period_start cycle.
  task automatic window(input string nm, input bit push, input logic [3:0] nd,
                        input int exp_hi, input int exp_unr);
    int hi, psn, psl;
    hi = 0; psn = 0; psl = 0;
    if (push) begin
      chk({nm, "_ready"}, int'(sample_ready), 1);
      sample_valid = 1'b1;
      sample_data  = nd;
    end
    for (int s = 1; s <= 32; s++) begin
      step();
      if (s == 1) sample_valid = 1'b0;
      hi  += int'(pwm_out);
      psn += int'(period_start);
      if (s == 32) psl = int'(period_start);
    end
    chk({nm, "_pwm_high"}, hi, exp_hi);
    chk({nm, "_ps_count"}, psn, 1);
    chk({nm, "_ps_at_32"}, psl, 1);
    chk({nm, "_underrun"}, int'(underrun), exp_unr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nready, waited;
    logic [3:0] nd;

    tbl[0] = '{duty: 4'd4,  mute: 1'b0, exp_hi: 8};
    tbl[1] = '{duty: 4'd4,  mute: 1'b0, exp_hi: 8};
    tbl[2] = '{duty: 4'd0,  mute: 1'b0, exp_hi: 0};
    tbl[3] = '{duty: 4'd15, mute: 1'b0, exp_hi: 30};
    tbl[4] = '{duty: 4'd7,  mute: 1'b1, exp_hi: 0};
    tbl[5] = '{duty: 4'd1,  mute: 1'b0, exp_hi: 2};

    reset = 1'b0; enable = 1'b0; rest = 1'b0;
    sample_data = '0; sample_valid = 1'b0; clr_underrun = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    chk("rst_ready", int'(sample_ready), 1);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_underrun", int'(underrun), 0);

    // First duty loaded while idle, then enable.
    sample_valid = 1'b1; sample_data = tbl[0].duty;
    step();
    sample_valid = 1'b0;
    chk("idle_ready_full", int'(sample_ready), 0);
    enable = 1'b1;
    step();
    chk("entry_ps", int'(period_start), 1);
    chk("entry_ready", int'(sample_ready), 1);

    for (int i = 0; i < 6; i++) begin
      nd = (i + 1 < 6) ? tbl[i + 1].duty : 4'd2;
      rest = tbl[i].mute;
      window($sformatf("row%0d", i), 1'b1, nd, tbl[i].exp_hi, 0);
      rest = 1'b0;
    end

    // Stall: 3 accepted mid-period, 9 held off until the boundary.
    repeat (5) step();
    sample_valid = 1'b1; sample_data = 4'd3;
    chk("stall_first_ready", int'(sample_ready), 1);
    step();
    sample_data = 4'd9;
    nready = 0; waited = 0;
    while (!period_start && waited < 40) begin
      nready += int'(sample_ready);
      step();
      waited++;
    end
    chk("stall_wait_bound", int'(waited < 40), 1);
    chk("stall_ready_cycles", nready, 0);
    window("stall_d3", 1'b1, 4'd9, 6, 0);

    // Underrun: no sample at boundary, previous duty repeats.
    window("unr_d9", 1'b0, 4'd0, 18, 1);
    window("unr_repeat", 1'b0, 4'd0, 18, 1);
    clr_underrun = 1'b1; step(); clr_underrun = 1'b0;
    chk("unr_clear", int'(underrun), 0);
    repeat (30) step();
    clr_underrun = 1'b1; step(); clr_underrun = 1'b0;
    chk("unr_set_wins", int'(underrun), 1);
    chk("unr_set_ps", int'(period_start), 1);

    // Bypass: sample on exactly the boundary cycle with shadow empty.
    clr_underrun = 1'b1; step(); clr_underrun = 1'b0;
    chk("byp_clear", int'(underrun), 0);
    repeat (30) step();
    sample_valid = 1'b1; sample_data = 4'd6;
    chk("byp_ready_in", int'(sample_ready), 1);
    step();
    sample_valid = 1'b0;
    chk("byp_ps", int'(period_start), 1);
    chk("byp_underrun", int'(underrun), 0);
    chk("byp_ready_out", int'(sample_ready), 1);
    window("byp_d6", 1'b1, 4'd10, 12, 0);

    // Asynchronous reset mid-period.
    repeat (5) step();
    chk("pre_rst_pwm", int'(pwm_out), 1);
    reset = 1'b0;
    #2;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_ps", int'(period_start), 0);
    chk("async_rst_unr", int'(underrun), 0);
    chk("async_rst_ready", int'(sample_ready), 1);
    reset = 1'b1;
    step();
    chk("post_rst_entry_ps", int'(period_start), 1);
    window("post_rst_d0", 1'b0, 4'd0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
- Downstream consumer of the register file's memory-mapped output register; turns WIDTH-bit duty samples into a single-bit PWM stream on the board's JB pin.
- Samples arrive over a valid/ready handshake into a one-deep shadow buffer.
- The active duty is swapped only at period boundaries, so no PWM period is ever truncated or glitched.
- Runs on the 25 MHz processor clock; a count tick comes from an internal prescaler.

Parameters:
- WIDTH, 8: duty/counter width; period = 2^WIDTH count ticks.
- PRESCALE, 50: clock cycles per count tick (25 MHz / 50 = 500 kHz tick). Must be ≥1.

Ports:
- clock  in  1  system clock (25 MHz).
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run PWM; low = idle.
- rest  in  1  mute; forces pwm_out low, timing continues.
- sample_data  in  WIDTH  duty value.
- sample_valid  in  1  sample_data valid.
- sample_ready  out  1  shadow buffer empty, can accept.
- clr_underrun  in  1  one-cycle pulse, clears underrun.
- pwm_out  out  1  registered PWM output (drives JB).
- period_start  out  1  one-cycle pulse when the counter wraps to 0.
- underrun  out  1  sticky: a period began with no fresh sample.

Behaviour:
- Reset (reset=0, asynchronous):
  - Zeroes the prescaler, count, active_duty, shadow, shadow_full, pwm_out, period_start, underrun and the FSM (IDLE).
  - sample_ready = !shadow_full, so it reads 1 immediately after reset.
- Handshake:
  - A transfer occurs when sample_valid && sample_ready on a rising edge.
  - sample_ready is combinational from shadow_full only and never depends on sample_valid.
- Prescaler:
  - In RUN, counts 0..PRESCALE-1 and wraps.
  - tick = 1 on the cycle the prescaler equals PRESCALE-1.
- Counter: WIDTH-bit, increments on tick and wraps from 2^WIDTH-1 to 0. boundary = tick && count == 2^WIDTH-1.
- FSM state IDLE (enable=0):
  - Prescaler and count held at 0; pwm_out=0; period_start=0; underrun is not set.
  - An accepted sample is moved shadow→active_duty on the next cycle, so the first RUN period uses it.
  - enable=1 → RUN on the next edge.
- FSM state RUN:
  - enable=0 → IDLE on the next edge.
  - The prescaler and counter restart from 0 on the next enable; active_duty is kept.
- Boundary swap, first matching case applies:
  - (a) shadow_full → active_duty ← shadow, shadow_full ← 0.
  - (b) shadow empty and a transfer in the same cycle → sample_data bypasses directly to active_duty; shadow stays empty.
  - (c) otherwise → active_duty is held (previous duty repeats) and underrun ← 1.
- Transfers off-boundary always write the shadow.
- Underrun: sticky until a clr_underrun pulse. If set and clear coincide, set wins.
- PWM compare:
  - pwm_out registered as enable && !rest && (count < active_duty), giving one cycle latency from count.
  - duty 0 → constant low; duty 2^WIDTH-1 → high for 2^WIDTH-1 of 2^WIDTH ticks.
  - Duty is never 100%, which is intended.
- period_start: registered from boundary, so it is high on the first cycle with count=0. It is also pulsed once on IDLE→RUN entry.
- rest: only gates pwm_out. Counter, swaps, period_start and underrun continue unchanged.
- Reset mid-period: everything returns to reset values at once, and pwm_out drops low asynchronously.
- Arithmetic: all unsigned. The count compare is WIDTH-bit; the prescaler is $clog2(PRESCALE) bits, minimum 1.

Decomposition:
- Shared package: FSM state encoding (IDLE, RUN) and the default WIDTH and PRESCALE values, reused by the regfile's MMIO decode.
- One sub-module, pwm_tick_gen: prescaler with an enable/clear input producing the tick pulse, reusable by the JB_clk divider.

Test Plan (bench overrides WIDTH=4, PRESCALE=2, so a period is 32 clocks):
- Reset, then push duty 4 with enable=0 and raise enable → sample_ready=1 after reset; period_start pulses on entry; pwm_out high for exactly 8 clocks of each 32 (1 cycle after count=0); underrun stays 0 while a fresh sample is pushed every period.
- Duties 0 and 15 → pwm_out never high for duty 0; high 30 of 32 clocks for duty 15.
- Push 3 mid-period, then 9 → first accepted; sample_ready=0 until the boundary, so 9 is stalled; at the boundary active=3, ready rises, 9 loads; next boundary active=9.
- No sample pushed at a boundary → underrun=1 and the previous duty repeats. clr_underrun pulse → 0. clr_underrun together with a new underrun event → stays 1.
- Sample 6 presented on exactly the boundary cycle with the shadow empty → used in the new period; underrun stays 0; shadow stays empty (ready remains 1).
- rest=1 mid-run → pwm_out=0 while period_start keeps 32-clock spacing. Deassert reset mid-period → all outputs 0 immediately; duty restarts at 0.
